letreiro_sequenciador: RTL and testbench

Sequencer for the three-word sign (bar / mosca / azul). It drives the 3-bit `palavras` word-enable bus through one of four stored lighting programs, with a programmable hold time per step and a programmable repeat count. It inserts a blank gap between repetitions and reports busy and completion status to the surrounding control logic. It replaces free-running sign counters, so the sign starts, stops and finishes under external command.

---
 rtl/letreiro_sequenciador.sv | 172 +++++++++++++++++
 tb/tb_letreiro_sequenciador.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/letreiro_sequenciador.sv
// Sequencer for the three-word sign (bar / mosca / azul).
// Plays one of four stored lighting programs with a programmable hold per step,
// a programmable repeat count and a blank gap between repetitions.
module letreiro_sequenciador #(
    parameter int GAP_CYCLES = 2,
    parameter int HOLD_W     = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              parar,
    input  logic [1:0]        modo,
    input  logic [HOLD_W-1:0] duracao,
    input  logic [3:0]        repeticoes,
    output logic [2:0]        palavras,
    output logic [3:0]        passo,
    output logic              ocupado,
    output logic              concluido
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {StIdle, StRun, StGap} estado_t;

    estado_t           estado;
    logic [1:0]        modo_l;
    logic [HOLD_W-1:0] dur_l;
    logic [3:0]        rep_l;
    logic [HOLD_W-1:0] hold_cnt;
    logic [3:0]        loop_cnt;
    logic [GW-1:0]     gap_cnt;

    // Stored programs: word pattern for program m at step s.
    function automatic logic [2:0] padrao(input logic [1:0] m, input logic [3:0] s);
        logic [2:0] p;
        p = 3'b000;
        unique case (m)
            2'd0: begin
                case (s)
                    4'd1:    p = 3'b100;
                    4'd2:    p = 3'b110;
                    4'd3:    p = 3'b111;
                    4'd4:    p = 3'b100;
                    4'd5:    p = 3'b011;
                    4'd7:    p = 3'b111;
                    4'd8:    p = 3'b010;
                    4'd9:    p = 3'b001;
                    default: p = 3'b000;
                endcase
            end
            2'd1: p = (s == 4'd0) ? 3'b111 : 3'b000;
            2'd2: begin
                case (s)
                    4'd0:    p = 3'b100;
                    4'd1:    p = 3'b010;
                    default: p = 3'b001;
                endcase
            end
            2'd3: begin
                case (s)
                    4'd0:    p = 3'b100;
                    4'd1:    p = 3'b110;
                    4'd2:    p = 3'b111;
                    default: p = 3'b000;
                endcase
            end
            default: p = 3'b000;
        endcase
        return p;
    endfunction

    // Index of the last step of program m.
    function automatic logic [3:0] ultimo(input logic [1:0] m);
        logic [3:0] u;
        unique case (m)
            2'd0:    u = 4'd9;
            2'd1:    u = 4'd1;
            2'd2:    u = 4'd2;
            default: u = 4'd3;
        endcase
        return u;
    endfunction

    // Sequencer FSM; every output is loaded with the value for the upcoming cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado    <= StIdle;
            modo_l    <= '0;
            dur_l     <= '0;
            rep_l     <= '0;
            hold_cnt  <= '0;
            loop_cnt  <= '0;
            gap_cnt   <= '0;
            palavras  <= '0;
            passo     <= '0;
            ocupado   <= 1'b0;
            concluido <= 1'b0;
        end else begin
            concluido <= 1'b0;
            unique case (estado)
                StIdle: begin
                    if (iniciar && !parar) begin
                        modo_l   <= modo;
                        dur_l    <= (duracao == '0) ? HOLD_W'(1) : duracao;
                        rep_l    <= repeticoes;
                        hold_cnt <= '0;
                        loop_cnt <= '0;
                        passo    <= '0;
                        palavras <= padrao(modo, 4'd0);
                        ocupado  <= 1'b1;
                        estado   <= StRun;
                    end
                end
                StRun: begin
                    if (parar) begin
                        estado   <= StIdle;
                        palavras <= '0;
                        passo    <= '0;
                        ocupado  <= 1'b0;
                    end else if (hold_cnt == dur_l - HOLD_W'(1)) begin
                        hold_cnt <= '0;
                        if (passo != ultimo(modo_l)) begin
                            passo    <= passo + 4'd1;
                            palavras <= padrao(modo_l, passo + 4'd1);
                        end else begin
                            loop_cnt <= loop_cnt + 4'd1;
                            passo    <= '0;
                            // Repeat count 0 means run until stopped.
                            if (rep_l != 4'd0 && loop_cnt + 4'd1 == rep_l) begin
                                estado    <= StIdle;
                                palavras  <= '0;
                                ocupado   <= 1'b0;
                                concluido <= 1'b1;
                            end else if (GAP_CYCLES == 0) begin
                                palavras <= padrao(modo_l, 4'd0);
                            end else begin
                                estado   <= StGap;
                                gap_cnt  <= '0;
                                palavras <= '0;
                            end
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                StGap: begin
                    if (parar) begin
                        estado   <= StIdle;
                        palavras <= '0;
                        passo    <= '0;
                        ocupado  <= 1'b0;
                    end else if (gap_cnt == GAP_LAST) begin
                        estado   <= StRun;
                        hold_cnt <= '0;
                        passo    <= '0;
                        palavras <= padrao(modo_l, 4'd0);
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: begin
                    estado   <= StIdle;
                    palavras <= '0;
                    passo    <= '0;
                    ocupado  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_letreiro_sequenciador.sv
// Self-checking bench for letreiro_sequenciador against a timeline-based reference model.
module tb_letreiro_sequenciador;

    localparam int G = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic       parar;
    logic [1:0] modo;
    logic [7:0] duracao;
    logic [3:0] repeticoes;
    logic [2:0] palavras;
    logic [3:0] passo;
    logic       ocupado;
    logic       concluido;

    int checks   = 0;
    int failures = 0;

    logic [2:0] pat [4][10];
    int         plen [4];

    letreiro_sequenciador #(
        .GAP_CYCLES(G),
        .HOLD_W    (8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .parar     (parar),
        .modo      (modo),
        .duracao   (duracao),
        .repeticoes(repeticoes),
        .palavras  (palavras),
        .passo     (passo),
        .ocupado   (ocupado),
        .concluido (concluido)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int t, input logic [3:0] got,
                       input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
        end
    endtask

    function automatic int fim_de(input int m, input int d, input int r);
        int dd;
        dd = (d == 0) ? 1 : d;
        return r * plen[m] * dd + (r - 1) * G;
    endfunction

    // Expected outputs t cycles after the start edge; p = edge offset of parar (0 = none).
    task automatic modelo(input int t, input int m, input int d, input int r, input int p,
                          output logic [2:0] ew, output logic [3:0] ep,
                          output logic eo, output logic ec);
        int dd, len, per, off, fim;
        dd  = (d == 0) ? 1 : d;
        len = plen[m] * dd;
        per = len + G;
        fim = fim_de(m, d, r);
        ew = 3'b000; ep = 4'd0; eo = 1'b0; ec = 1'b0;
        if (p != 0 && t >= p) begin
            ec = 1'b0;
        end else if (r != 0 && t >= fim) begin
            ec = (t == fim);
        end else begin
            eo  = 1'b1;
            off = t % per;
            if (off < len) begin
                ep = 4'(off / dd);
                ew = pat[m][off / dd];
            end
        end
    endtask

    // One run: start, then compare every cycle; ruido toggles ignored inputs mid-run.
    task automatic run(input int m, input int d, input int r, input int p, input bit ruido);
        int fim, lim, n;
        logic [2:0] ew;
        logic [3:0] ep;
        logic eo, ec;
        fim = fim_de(m, d, r);
        lim = 1 << 30;
        if (r != 0) lim = fim;
        if (p != 0 && p < lim) lim = p;
        n = lim + 3;
        @(negedge clock);
        modo = 2'(m); duracao = 8'(d); repeticoes = 4'(r); iniciar = 1'b1; parar = 1'b0;
        for (int t = 0; t < n; t++) begin
            @(negedge clock);
            modelo(t, m, d, r, p, ew, ep, eo, ec);
            chk("palavras", t, {1'b0, palavras}, {1'b0, ew});
            chk("passo", t, passo, ep);
            chk("ocupado", t, {3'b0, ocupado}, {3'b0, eo});
            chk("concluido", t, {3'b0, concluido}, {3'b0, ec});
            iniciar = (ruido && t + 1 <= lim) ? 1'($urandom_range(0, 1)) : 1'b0;
            parar   = (p != 0 && t + 1 == p);
            if (ruido) begin
                modo       = 2'($urandom_range(0, 3));
                duracao    = 8'($urandom_range(0, 7));
                repeticoes = 4'($urandom_range(0, 15));
            end
        end
        iniciar = 1'b0;
        parar   = 1'b0;
    endtask

    initial begin
        int m, d, r, p, fim;
        plen[0] = 10; plen[1] = 2; plen[2] = 3; plen[3] = 4;
        for (int i = 0; i < 4; i++) for (int j = 0; j < 10; j++) pat[i][j] = 3'b000;
        pat[0][0] = 3'b000; pat[0][1] = 3'b100; pat[0][2] = 3'b110; pat[0][3] = 3'b111;
        pat[0][4] = 3'b100; pat[0][5] = 3'b011; pat[0][6] = 3'b000; pat[0][7] = 3'b111;
        pat[0][8] = 3'b010; pat[0][9] = 3'b001;
        pat[1][0] = 3'b111; pat[1][1] = 3'b000;
        pat[2][0] = 3'b100; pat[2][1] = 3'b010; pat[2][2] = 3'b001;
        pat[3][0] = 3'b100; pat[3][1] = 3'b110; pat[3][2] = 3'b111; pat[3][3] = 3'b000;

        reset = 1'b0; iniciar = 1'b0; parar = 1'b0;
        modo = 2'd0; duracao = 8'd0; repeticoes = 4'd0;
        repeat (2) @(negedge clock);
        chk("rst_palavras", 0, {1'b0, palavras}, 4'h0);
        chk("rst_passo", 0, passo, 4'h0);
        chk("rst_ocupado", 0, {3'b0, ocupado}, 4'h0);
        chk("rst_concluido", 0, {3'b0, concluido}, 4'h0);
        reset = 1'b1;

        // Directed cases from the plan.
        run(0, 1, 1, 0, 1'b0);
        run(2, 3, 2, 0, 1'b0);
        run(1, 0, 3, 0, 1'b0);
        run(3, 2, 0, 105, 1'b1);
        run(0, 2, 1, 0, 1'b1);
        run(2, 255, 1, 0, 1'b1);
        run(1, 1, 2, 4, 1'b0);

        // iniciar and parar together in IDLE must not start.
        @(negedge clock);
        modo = 2'd1; duracao = 8'd1; repeticoes = 4'd1; iniciar = 1'b1; parar = 1'b1;
        @(negedge clock);
        chk("both_ocupado", 0, {3'b0, ocupado}, 4'h0);
        chk("both_palavras", 0, {1'b0, palavras}, 4'h0);
        iniciar = 1'b0; parar = 1'b0;

        // Asynchronous reset mid-run.
        @(negedge clock);
        modo = 2'd1; duracao = 8'd1; repeticoes = 4'd0; iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        repeat (2) @(negedge clock);
        chk("pre_rst_ocupado", 0, {3'b0, ocupado}, 4'h1);
        #2 reset = 1'b0;
        #1;
        chk("arst_palavras", 0, {1'b0, palavras}, 4'h0);
        chk("arst_passo", 0, passo, 4'h0);
        chk("arst_ocupado", 0, {3'b0, ocupado}, 4'h0);
        chk("arst_concluido", 0, {3'b0, concluido}, 4'h0);
        @(negedge clock);
        reset = 1'b1;
        run(3, 1, 1, 0, 1'b0);

        // Randomized runs.
        for (int k = 0; k < 10; k++) begin
            m = $urandom_range(0, 3);
            d = $urandom_range(0, 4);
            r = $urandom_range(0, 3);
            fim = fim_de(m, d, r);
            if (r == 0) p = $urandom_range(1, 40);
            else if ($urandom_range(0, 1) == 1) p = $urandom_range(1, fim);
            else p = 0;
            run(m, d, r, p, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
